// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer for the RISC core.
// Latency: a fetch completes 2 cycles after entering FETCH at best (req, then ack); one bubble after reset.
// Backpressure: while decode holds ready_in low, the instruction stays registered and no new request is made.
//
// Ports:
//   clk, rst              - clock; synchronous active-high reset
//   next_pc               - next-PC mux output, loaded into pc when decode takes the instruction
//   pc_plus_4             - pc + 4, fed back to the next-PC mux as a candidate
//   flush, flush_pc       - redirect; beats everything except rst (ignored once halted)
//   halt                  - park after the current instruction is handed off
//   imem_req/addr/ack/rdata - instruction memory req/ack handshake
//   instr, instr_valid, ready_in - fetched instruction to decode, valid/ready
//   pc                    - address of the instruction in flight / on instr
//   halted, err           - parked flag; sticky error (1 = ack timeout, 2 = misaligned pc)
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        ready_in,
    output logic [31:0] pc,
    output logic [31:0] pc_plus_4,
    output logic        halted,
    output logic [1:0]  err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_HOLD   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_MISALIGN = 2'd2;

    // Wait counter is 8 bits wide since ACK_TIMEOUT tops out at 255.
    localparam logic [7:0] WAIT_MAX  = 8'(ACK_TIMEOUT);
    localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        vld_q, vld_d;
    logic [1:0]  err_q, err_d;
    logic [7:0]  wait_q, wait_d;
    // Address of the request still outstanding after a flush out of FETCH.
    logic [31:0] drain_q, drain_d;

    logic        pc_load;
    logic [7:0]  wait_inc;
    logic        wait_expired;

    // Saturating increment; the counter never wraps back to zero.
    assign wait_inc     = (wait_q >= WAIT_MAX) ? wait_q : wait_q + 8'd1;
    // True when this no-ack cycle is the ACK_TIMEOUT-th one.
    assign wait_expired = (wait_q >= WAIT_LAST);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        vld_d   = vld_q;
        err_d   = err_q;
        wait_d  = wait_q;
        drain_d = drain_q;
        pc_load = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    pc_load = 1'b1;
                    wait_d  = 8'd0;
                    state_d = S_FETCH;
                end else if (halt) begin
                    state_d = S_HALTED;
                end else begin
                    wait_d  = 8'd0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    pc_load = 1'b1;
                    vld_d   = 1'b0;
                    wait_d  = 8'd0;
                    if (imem_ack) begin
                        // Returned word belongs to the old path; drop it and refetch.
                        state_d = S_FETCH;
                    end else begin
                        // Memory still owes us a response for the old address.
                        drain_d = pc_q;
                        state_d = S_DRAIN;
                    end
                end else if (imem_ack) begin
                    instr_d = imem_rdata;
                    vld_d   = 1'b1;
                    wait_d  = 8'd0;
                    state_d = S_HOLD;
                end else if (wait_expired) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_HALTED;
                end else begin
                    wait_d  = wait_inc;
                end
            end

            S_HOLD: begin
                if (flush) begin
                    // The held instruction is discarded, not handed off.
                    pc_d    = flush_pc;
                    pc_load = 1'b1;
                    vld_d   = 1'b0;
                    wait_d  = 8'd0;
                    state_d = S_FETCH;
                end else if (ready_in) begin
                    pc_d    = next_pc;
                    pc_load = 1'b1;
                    vld_d   = 1'b0;
                    wait_d  = 8'd0;
                    state_d = halt ? S_HALTED : S_FETCH;
                end
            end

            S_DRAIN: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    pc_load = 1'b1;
                end
                if (imem_ack) begin
                    wait_d  = 8'd0;
                    state_d = S_FETCH;
                end else if (flush) begin
                    // Redirect again while draining: keep waiting, keep counting.
                    wait_d  = wait_inc;
                end else if (wait_expired) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_HALTED;
                end else begin
                    wait_d  = wait_inc;
                end
            end

            S_HALTED: begin
                state_d = S_HALTED;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Any misaligned pc load is still taken, but parks the unit.
        if (pc_load && (pc_d[1:0] != 2'b00)) begin
            err_d   = ERR_MISALIGN;
            state_d = S_HALTED;
        end

        if (state_d == S_HALTED) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
            vld_q   <= 1'b0;
            err_q   <= ERR_NONE;
            wait_q  <= 8'd0;
            drain_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
            drain_q <= drain_d;
        end
    end

    assign imem_req    = (state_q == S_FETCH) || (state_q == S_DRAIN);
    // DRAIN keeps presenting the old address until its ack arrives.
    assign imem_addr   = (state_q == S_DRAIN) ? drain_q : pc_q;
    assign instr       = instr_q;
    assign instr_valid = vld_q;
    assign pc          = pc_q;
    assign pc_plus_4   = pc_q + 32'd4;
    assign halted      = (state_q == S_HALTED);
    assign err         = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus a randomized run
// checked against a transaction-level model of which address decode must see.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] next_pc = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        halt = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        ready_in = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        halted;
    logic [1:0]  err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .next_pc(next_pc), .flush(flush), .flush_pc(flush_pc),
        .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .ready_in(ready_in), .pc(pc), .pc_plus_4(pc_plus_4), .halted(halted), .err(err)
    );

    // Instruction memory: contents are a fixed function of the address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    bit          mem_on    = 1'b1;
    bit          rand_lat  = 1'b0;
    int          ack_delay = 1;
    int          age       = 0;
    int          cur_delay = 1;
    logic [31:0] ack_log[$];

    // Acks a request after it has been pending for cur_delay+1 cycles.
    always @(negedge clk) begin
        if (rst || !imem_req || !mem_on) begin
            age      = 0;
            imem_ack = 1'b0;
        end else begin
            if (imem_ack) age = 0;
            age = age + 1;
            if (age == 1) cur_delay = rand_lat ? int'($urandom_range(0, 3)) : ack_delay;
            imem_ack   = (age > cur_delay);
            imem_rdata = imem_ack ? word_at(imem_addr) : $urandom;
            if (imem_ack) ack_log.push_back(imem_addr);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; halt = 1'b0; ready_in = 1'b0;
        next_pc = 32'h0; flush_pc = 32'h0;
        repeat (3) tick();
        ack_log.delete();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ready_in = 1'b1; flush = 1'b1; flush_pc = 32'h44;
        repeat (3) tick();
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want %h", instr, 32'h0); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_checks++; if (err !== 2'd0) begin n_fail++; $display("FAIL reset_err: got %0d want 0", err); end
        n_checks++; if (pc_plus_4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc_plus_4: got %h want %h", pc_plus_4, 32'h4); end
        flush = 1'b0; ready_in = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        int got, last, first;
        mem_on = 1'b1; rand_lat = 1'b0; ack_delay = 1;
        do_reset();
        exp = 32'h0; got = 0; last = 0; first = -1; ready_in = 1'b1;
        for (int i = 0; i < 40 && got < 4; i++) begin
            tick();
            next_pc = exp + 32'd4;
            if (instr_valid && ready_in) begin
                n_checks++; if (pc !== exp) begin n_fail++; $display("FAIL stream_pc: got %h want %h", pc, exp); end
                n_checks++; if (instr !== word_at(exp)) begin n_fail++; $display("FAIL stream_instr: got %h want %h", instr, word_at(exp)); end
                if (got == 0) first = i;
                else begin
                    n_checks++; if (i - last != 3) begin n_fail++; $display("FAIL stream_interval: got %0d want 3", i - last); end
                end
                last = i; got++; exp = exp + 32'd4;
            end
        end
        tick();
        ready_in = 1'b0;
        n_checks++; if (got != 4) begin n_fail++; $display("FAIL stream_count: got %0d want 4", got); end
        n_checks++; if (first != 2) begin n_fail++; $display("FAIL stream_first_latency: got %0d want 2", first); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (ack_log.size() <= k || ack_log[k] !== 32'(k * 4)) begin
                n_fail++; $display("FAIL stream_addr_seq[%0d]: got %h want %h", k, (ack_log.size() > k) ? ack_log[k] : 32'hx, 32'(k * 4));
            end
        end
    endtask

    task automatic test_hold_stall();
        bit ok;
        wait_valid(10, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_wait_valid: got timeout want instr_valid"); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({instr_valid, imem_req, pc, instr} !== {1'b1, 1'b0, 32'h10, word_at(32'h10)}) begin
                n_fail++; $display("FAIL stall_stable: got v=%b req=%b pc=%h instr=%h want v=1 req=0 pc=%h instr=%h",
                                   instr_valid, imem_req, pc, instr, 32'h10, word_at(32'h10));
            end
        end
        next_pc = 32'h40; ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL stall_pc_load: got %h want %h", pc, 32'h40); end
        n_checks++; if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h40}) begin
            n_fail++; $display("FAIL stall_refetch: got v=%b req=%b addr=%h want v=0 req=1 addr=40", instr_valid, imem_req, imem_addr); end
        wait_valid(10, ok);
        n_checks++; if (!ok || instr !== word_at(32'h40)) begin n_fail++; $display("FAIL stall_next_instr: got %h want %h", instr, word_at(32'h40)); end
    endtask

    task automatic test_flush_drain();
        bit seen, stale;
        ack_delay = 4;
        next_pc = 32'h44; ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h44}) begin n_fail++; $display("FAIL drain_fetch: got req=%b addr=%h want req=1 addr=44", imem_req, imem_addr); end
        flush = 1'b1; flush_pc = 32'h100;
        tick();
        flush = 1'b0;
        n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL drain_pc: got %h want %h", pc, 32'h100); end
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h44}) begin n_fail++; $display("FAIL drain_old_addr: got req=%b addr=%h want req=1 addr=44", imem_req, imem_addr); end
        seen = 1'b0; stale = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (instr_valid) begin
                seen = 1'b1;
                if (pc !== 32'h100) stale = 1'b1;
                break;
            end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL drain_wait_valid: got timeout want instr_valid"); end
        n_checks++; if (stale) begin n_fail++; $display("FAIL drain_stale_valid: got valid for dropped word want none"); end
        n_checks++; if (instr !== word_at(32'h100)) begin n_fail++; $display("FAIL drain_new_instr: got %h want %h", instr, word_at(32'h100)); end
        n_checks++;
        if (ack_log.size() < 2 || ack_log[ack_log.size()-2] !== 32'h44 || ack_log[ack_log.size()-1] !== 32'h100) begin
            n_fail++; $display("FAIL drain_ack_order: got %0d acks want ...,44,100", ack_log.size());
        end
        ack_delay = 1;
    endtask

    task automatic test_flush_ready();
        bit ok;
        ready_in = 1'b1; next_pc = 32'h8; flush = 1'b1; flush_pc = 32'h200;
        tick();
        flush = 1'b0; ready_in = 1'b0;
        n_checks++; if (pc !== 32'h200) begin n_fail++; $display("FAIL flushready_pc: got %h want %h", pc, 32'h200); end
        n_checks++; if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
            n_fail++; $display("FAIL flushready_fetch: got v=%b req=%b addr=%h want v=0 req=1 addr=200", instr_valid, imem_req, imem_addr); end
        wait_valid(10, ok);
        n_checks++; if (!ok || instr !== word_at(32'h200)) begin n_fail++; $display("FAIL flushready_instr: got %h want %h", instr, word_at(32'h200)); end
    endtask

    task automatic test_wrap();
        bit ok;
        flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        n_checks++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", pc, 32'hFFFF_FFFC); end
        n_checks++; if (pc_plus_4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc_plus_4: got %h want %h", pc_plus_4, 32'h0); end
        wait_valid(10, ok);
        n_checks++; if (!ok || instr !== word_at(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap_instr: got %h want %h", instr, word_at(32'hFFFF_FFFC)); end
        // Reset while holding a valid instruction, with decode ready.
        rst = 1'b1; ready_in = 1'b1;
        tick();
        n_checks++; if ({instr_valid, imem_req, pc} !== {1'b0, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL wrap_rst_override: got v=%b req=%b pc=%h want v=0 req=0 pc=0", instr_valid, imem_req, pc); end
        rst = 1'b0; ready_in = 1'b0;
    endtask

    task automatic test_halt();
        bit ok;
        do_reset();
        wait_valid(10, ok);
        n_checks++; if (!ok || pc !== 32'h0) begin n_fail++; $display("FAIL halt_first_pc: got %h want %h", pc, 32'h0); end
        halt = 1'b1; ready_in = 1'b1; next_pc = 32'h20;
        tick();
        ready_in = 1'b0;
        n_checks++; if ({halted, err, instr_valid, imem_req} !== {1'b1, 2'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL halt_handoff: got halted=%b err=%0d v=%b req=%b want halted=1 err=0 v=0 req=0", halted, err, instr_valid, imem_req); end
        n_checks++; if (pc !== 32'h20) begin n_fail++; $display("FAIL halt_pc: got %h want %h", pc, 32'h20); end
        // halt seen straight out of reset parks from IDLE.
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        n_checks++; if ({halted, imem_req} !== 2'b10) begin n_fail++; $display("FAIL halt_idle: got halted=%b req=%b want halted=1 req=0", halted, imem_req); end
        halt = 1'b0; flush = 1'b1; flush_pc = 32'h300;
        tick();
        flush = 1'b0;
        n_checks++; if ({halted, pc} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL halt_ignore_flush: got halted=%b pc=%h want halted=1 pc=0", halted, pc); end
    endtask

    task automatic test_timeout();
        int reqs;
        bit done;
        mem_on = 1'b0;
        do_reset();
        reqs = 0; done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (halted) begin done = 1'b1; break; end
            if (imem_req) reqs++;
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL timeout_halt: got no halt want halted"); end
        n_checks++; if (reqs != 16) begin n_fail++; $display("FAIL timeout_wait_cycles: got %0d want 16", reqs); end
        n_checks++; if (err !== 2'd1) begin n_fail++; $display("FAIL timeout_err: got %0d want 1", err); end
        flush = 1'b1; ready_in = 1'b1; halt = 1'b1; flush_pc = 32'h80;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({halted, err, imem_req, instr_valid} !== {1'b1, 2'd1, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL timeout_sticky: got halted=%b err=%0d req=%b v=%b want halted=1 err=1 req=0 v=0", halted, err, imem_req, instr_valid);
            end
        end
        flush = 1'b0; ready_in = 1'b0; halt = 1'b0;
        rst = 1'b1;
        tick();
        n_checks++; if ({halted, err} !== {1'b0, 2'd0}) begin n_fail++; $display("FAIL timeout_rst_clear: got halted=%b err=%0d want 0 0", halted, err); end
        mem_on = 1'b1;
        rst = 1'b0;
    endtask

    task automatic test_misaligned();
        bit ok;
        do_reset();
        wait_valid(10, ok);
        next_pc = 32'h6; ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        n_checks++; if ({err, halted} !== {2'd2, 1'b1}) begin n_fail++; $display("FAIL misalign_err: got err=%0d halted=%b want err=2 halted=1", err, halted); end
        n_checks++; if (pc !== 32'h6) begin n_fail++; $display("FAIL misalign_pc: got %h want %h", pc, 32'h6); end
        repeat (3) tick();
        n_checks++; if ({imem_req, instr_valid, err} !== {1'b0, 1'b0, 2'd2}) begin
            n_fail++; $display("FAIL misalign_parked: got req=%b v=%b err=%0d want req=0 v=0 err=2", imem_req, instr_valid, err); end
        // Misaligned redirect target while a fetch is pending.
        do_reset();
        repeat (2) tick();
        flush = 1'b1; flush_pc = 32'h102;
        tick();
        flush = 1'b0;
        n_checks++; if ({err, halted, imem_req, pc} !== {2'd2, 1'b1, 1'b0, 32'h102}) begin
            n_fail++; $display("FAIL misalign_flush: got err=%0d halted=%b req=%b pc=%h want err=2 halted=1 req=0 pc=102", err, halted, imem_req, pc); end
    endtask

    task automatic test_random();
        logic [31:0] exp;
        int handoffs;
        bit flushed;
        rand_lat = 1'b1;
        do_reset();
        exp = 32'h0; handoffs = 0; flushed = 1'b0;
        for (int i = 0; i < 800; i++) begin
            tick();
            n_checks++; if (pc !== exp || halted !== 1'b0) begin n_fail++; $display("FAIL rand_pc[%0d]: got %h halted=%b want %h halted=0", i, pc, halted, exp); end
            if (flushed) begin
                n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rand_flush_valid[%0d]: got %b want 0", i, instr_valid); end
            end
            if (instr_valid) begin
                n_checks++; if (instr !== word_at(exp)) begin n_fail++; $display("FAIL rand_instr[%0d]: got %h want %h", i, instr, word_at(exp)); end
            end
            flush    = ($urandom_range(0, 15) == 0);
            flush_pc = $urandom_range(0, 32'h3FF) & 32'hFFFF_FFFC;
            ready_in = $urandom_range(0, 1) == 1;
            next_pc  = $urandom_range(0, 32'hFFF) & 32'hFFFF_FFFC;
            flushed  = flush;
            if (flush) exp = flush_pc;
            else if (instr_valid && ready_in) begin
                exp = next_pc;
                handoffs++;
            end
        end
        flush = 1'b0; ready_in = 1'b0; rand_lat = 1'b0;
        n_checks++; if (handoffs < 20) begin n_fail++; $display("FAIL rand_handoffs: got %0d want >= 20", handoffs); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold_stall();
        test_flush_drain();
        test_flush_ready();
        test_wrap();
        test_halt();
        test_timeout();
        test_misaligned();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit reached want end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
